// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: one bit per cycle, result valid XLEN+1 edges after accept (1 edge for divide-by-zero).
// Result is held in DONE until ready_i; new requests are refused while busy, and flush_i aborts from any state.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] r0data_i,
  input  logic [XLEN-1:0] r1data_i,
  input  logic            flush_i,
  output logic            valid_ro,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_ro,
  output logic            busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        r_f3;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_dz;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;

  logic              w_sa;
  logic              w_sb;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div0;
  logic              w_last;
  logic              w_qbit;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  assign ready_o = (r_state == S_IDLE) & ~flush_i;
  assign busy_o  = (r_state != S_IDLE);

  // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 is unsigned for MULHSU as well
  assign w_sa    = ~((funct3_i == 3'b011) | (funct3_i[2] & funct3_i[0]));
  assign w_sb    = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
  assign w_a_neg = w_sa & r0data_i[XLEN-1];
  assign w_b_neg = w_sb & r1data_i[XLEN-1];
  assign w_a_mag = w_a_neg ? -r0data_i : r0data_i;
  assign w_b_mag = w_b_neg ? -r1data_i : r1data_i;
  assign w_div0  = funct3_i[2] & (r1data_i == '0);
  assign w_last  = (r_cnt == CNT_W'(XLEN - 1));

  // MUL: r_acc = {partial product, remaining multiplier bits}; r_b = multiplicand
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + ({(XLEN+1){r_acc[0]}} & {1'b0, r_b});

  // DIV: r_acc = {partial remainder, dividend bits / quotient bits}; r_b = divisor
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
  assign w_qbit      = ~w_div_trial[XLEN];

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    if (r_dz)
      w_fix_res = r_f3[1] ? r_acc[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
    else if (!r_f3[2])
      w_fix_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else
      w_fix_res = r_f3[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      valid_ro  <= 1'b0;
      result_ro <= '0;
    end else if (flush_i) begin
      r_state  <= S_IDLE;
      valid_ro <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_f3    <= funct3_i;
            r_neg_a <= w_a_neg;
            r_neg_b <= w_b_neg;
            r_dz    <= w_div0;
            r_cnt   <= '0;
            if (w_div0) begin
              // Zero divisor skips iteration; FIXUP picks all-ones or the raw dividend
              r_acc   <= {{XLEN{1'b1}}, r0data_i};
              r_state <= S_FIXUP;
            end else if (funct3_i[2]) begin
              r_acc   <= {{XLEN{1'b0}}, w_a_mag};
              r_b     <= w_b_mag;
              r_state <= S_DIV;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_b_mag};
              r_b     <= w_a_mag;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIXUP;
        end
        S_DIV: begin
          r_acc <= {(w_qbit ? w_div_trial[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1]),
                    r_acc[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          result_ro <= w_fix_res;
          valid_ro  <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (ready_i) begin
            valid_ro <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised and directed bench for muldiv_sequencer against a cycle-level transaction model.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] r0data_i = '0;
  logic [31:0] r1data_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_ro;
  logic        ready_i = 1'b0;
  logic [31:0] result_ro;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .r0data_i(r0data_i), .r1data_i(r1data_i),
    .flush_i(flush_i), .valid_ro(valid_ro), .ready_i(ready_i),
    .result_ro(result_ro), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    p = '0;
    ref_op = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; ref_op = p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); ref_op = p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); ref_op = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; ref_op = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_op = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_op = 32'h80000000;
        else ref_op = sa / sb;
      end
      3'd5: ref_op = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) ref_op = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_op = 32'h0;
        else ref_op = sa % sb;
      end
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Transaction model: busy/valid/result as seen by the pins
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pend  = '0;
  int          m_left  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_res   <= '0;
    end else if (flush_i) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (valid_i) begin
        m_busy <= 1'b1;
        m_pend <= ref_op(funct3_i, r0data_i, r1data_i);
        m_left <= (funct3_i[2] && r1data_i == 0) ? 1 : XLEN + 1;
      end
    end else if (m_valid) begin
      if (ready_i) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    check1("ready_o", ready_o, !m_busy && !flush_i);
    check1("busy_o", busy_o, m_busy);
    check1("valid_ro", valid_ro, m_valid);
    check("result_ro", result_ro, m_res);
  end

  // Called #1 after an edge with the DUT idle; returns in the same condition.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    funct3_i = f3; r0data_i = a; r1data_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; r0data_i = $urandom; r1data_i = $urandom; funct3_i = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid_ro && lat < 100);
    check("latency", lat, exp_lat);
    check("op_result", result_ro, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check1("bp_valid", valid_ro, 1'b1);
      check1("bp_ready", ready_o, 1'b0);
      check1("bp_busy", busy_o, 1'b1);
      check("bp_result", result_ro, exp);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check1("after_hs_valid", valid_ro, 1'b0);
  endtask

  task automatic do_flushed(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int k);
    funct3_i = f3; r0data_i = a; r1data_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check1("flush_busy", busy_o, 1'b0);
    check1("flush_valid", valid_ro, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'h1;
      2: pick = 32'hFFFFFFFF;
      3: pick = 32'h80000000;
      4: pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_valid", valid_ro, 1'b0);
    check("rst_result", result_ro, 32'h0);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_ready", ready_o, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    do_op(3'd5, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1, 0);
    do_op(3'd6, 32'h00001234, 32'd0,        32'h00001234, 1, 0);
    do_op(3'd0, 32'd3,        32'd5,        32'd15,       33, 5);

    // Abort a divide at iteration 10, then a multiply accepted on the very next cycle
    do_flushed(3'd4, 32'd1000, 32'd7, 9);
    do_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 33, 0);

    // Flush while a result waits in DONE: result is dropped but result_ro keeps its value
    funct3_i = 3'd0; r0data_i = 32'd3; r1data_i = 32'd4; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (35) begin @(posedge clk); #1; end
    held = result_ro;
    check("done_result", held, 32'd12);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check1("done_flush_valid", valid_ro, 1'b0);
    check("done_flush_result", result_ro, 32'd12);

    // Flush beats a simultaneous request
    funct3_i = 3'd0; r0data_i = 32'd9; r1data_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check1("flush_vs_accept", busy_o, 1'b0);

    // Reset in the middle of an operation
    funct3_i = 3'd5; r0data_i = 32'd100; r1data_i = 32'd3; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check1("midrst_busy", busy_o, 1'b0);
    check("midrst_result", result_ro, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 5) == 0)
        do_flushed(f3, a, b, $urandom_range(0, 36));
      else
        do_op(f3, a, b, ref_op(f3, a, b), (f3[2] && b == 0) ? 1 : 33, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
